fix_field_sequencer: RTL and testbench

// - Drains the paired tag FIFO (32b) and value FIFO (256b) filled by the FIX tag/value extractor.
// - Pops one tag/value pair at a time and presents it downstream as one field record over valid/ready.
// - Tracks message framing: tag "8" opens a message, tag "10" closes it. Reports framing errors and FIFO desync.

---
 rtl/fix_pkg.sv | 22 ++
 rtl/fix_desync_watchdog.sv | 33 +++
 rtl/fix_field_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_fix_field_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fix_pkg.sv
// Shared constants and enums for the FIX field sequencer.
package fix_pkg;

    localparam logic [31:0] TAG_BEGIN_STRING = 32'h0000_0038;
    localparam logic [31:0] TAG_CHECKSUM     = 32'h0000_3130;

    typedef enum logic [2:0] {
        ERR_NONE       = 3'd0,
        ERR_ORPHAN     = 3'd1,
        ERR_NO_TRAILER = 3'd2,
        ERR_OVERFLOW   = 3'd3,
        ERR_DESYNC     = 3'd4
    } err_code_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_CLASSIFY,
        ST_HOLD
    } seq_state_e;

endpackage

// File: rtl/fix_desync_watchdog.sv
// Flags when one FIFO has held data for DESYNC_CYC consecutive cycles while the other stayed empty.
module fix_desync_watchdog #(
    parameter int DESYNC_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic t_empty,
    input  logic v_empty,
    output logic pulse
);

    localparam int CNT_W = (DESYNC_CYC < 2) ? 1 : $clog2(DESYNC_CYC + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_mismatch;
    logic             w_hit;

    assign w_mismatch = t_empty ^ v_empty;
    // r_cnt holds the mismatch cycles already seen, so the current one is r_cnt+1
    assign w_hit      = w_mismatch && (r_cnt == CNT_W'(DESYNC_CYC - 1));
    assign pulse      = w_hit && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!w_mismatch || w_hit) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fix_field_sequencer.sv
// Pops paired tag/value FIFO entries and presents them as framed FIX field records.
//   state       | meaning
//   ST_IDLE     | wait for both FIFOs non-empty, pop both together
//   ST_READ     | capture FIFO read data into the record registers
//   ST_CLASSIFY | framing checks; drop, flag, or accept the field
//   ST_HOLD     | record valid, held stable until fld_ready_i
module fix_field_sequencer
    import fix_pkg::*;
#(
    parameter int TAG_W      = 32,
    parameter int VAL_W      = 256,
    parameter int IDX_W      = 8,
    parameter int MAX_FIELDS = 64,
    parameter int DESYNC_CYC = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             t_empty_i,
    output logic             t_rd_en_o,
    input  logic [TAG_W-1:0] t_data_i,
    input  logic             v_empty_i,
    output logic             v_rd_en_o,
    input  logic [VAL_W-1:0] v_data_i,
    output logic             fld_valid_o,
    input  logic             fld_ready_i,
    output logic [TAG_W-1:0] fld_tag_o,
    output logic [VAL_W-1:0] fld_value_o,
    output logic [IDX_W-1:0] fld_idx_o,
    output logic             fld_sof_o,
    output logic             fld_eof_o,
    output logic [15:0]      msg_cnt_o,
    output logic             err_o,
    output logic [2:0]       err_code_o
);

    seq_state_e       r_state;
    seq_state_e       w_state_nxt;
    logic [TAG_W-1:0] r_tag;
    logic [VAL_W-1:0] r_value;
    logic [IDX_W-1:0] r_idx;
    logic             r_sof;
    logic             r_eof;
    logic             r_in_msg;
    logic [IDX_W:0]   r_count;
    logic [15:0]      r_msg_cnt;
    err_code_e        r_err_code;

    logic             w_is_begin;
    logic             w_is_end;
    logic             w_desync;
    logic             w_pop;
    logic             w_present;
    logic             w_overflow;
    logic             w_cls_err;
    err_code_e        w_cls_code;
    logic             w_handshake;

    assign w_is_begin  = (r_tag == TAG_W'(TAG_BEGIN_STRING));
    assign w_is_end    = (r_tag == TAG_W'(TAG_CHECKSUM));
    assign w_handshake = (r_state == ST_HOLD) && fld_ready_i;

    fix_desync_watchdog #(
        .DESYNC_CYC(DESYNC_CYC)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .t_empty(t_empty_i),
        .v_empty(v_empty_i),
        .pulse  (w_desync)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_present   = 1'b0;
        w_overflow  = 1'b0;
        w_cls_err   = 1'b0;
        w_cls_code  = ERR_NONE;
        case (r_state)
            ST_IDLE: begin
                if (!t_empty_i && !v_empty_i) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                w_state_nxt = ST_CLASSIFY;
            end
            ST_CLASSIFY: begin
                if (!r_in_msg && !w_is_begin) begin
                    w_cls_err   = 1'b1;
                    w_cls_code  = ERR_ORPHAN;
                    w_state_nxt = ST_IDLE;
                end else if (r_in_msg && w_is_begin) begin
                    w_cls_err   = 1'b1;
                    w_cls_code  = ERR_NO_TRAILER;
                    w_present   = 1'b1;
                    w_state_nxt = ST_HOLD;
                end else if (r_in_msg && (r_count == (IDX_W+1)'(MAX_FIELDS)) && !w_is_end) begin
                    w_cls_err   = 1'b1;
                    w_cls_code  = ERR_OVERFLOW;
                    w_overflow  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_present   = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (fld_ready_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_tag      <= '0;
            r_value    <= '0;
            r_idx      <= '0;
            r_sof      <= 1'b0;
            r_eof      <= 1'b0;
            r_in_msg   <= 1'b0;
            r_count    <= '0;
            r_msg_cnt  <= '0;
            r_err_code <= ERR_NONE;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_READ) begin
                r_tag   <= t_data_i;
                r_value <= v_data_i;
            end
            // a "8" always restarts numbering, including the unterminated-message case
            if (w_present) begin
                r_sof <= w_is_begin;
                r_eof <= w_is_end;
                if (w_is_begin) begin
                    r_idx    <= '0;
                    r_count  <= '0;
                    r_in_msg <= 1'b1;
                end else begin
                    r_idx <= r_count[IDX_W-1:0];
                end
            end
            if (w_overflow) begin
                r_in_msg <= 1'b0;
                r_count  <= '0;
            end
            if (w_handshake) begin
                if (r_eof) begin
                    r_count   <= '0;
                    r_in_msg  <= 1'b0;
                    r_msg_cnt <= r_msg_cnt + 16'd1;
                end else begin
                    r_count <= r_count + (IDX_W+1)'(1);
                end
            end
            if (w_desync || w_cls_err) begin
                r_err_code <= w_desync ? ERR_DESYNC : w_cls_code;
            end
        end
    end

    assign t_rd_en_o   = w_pop && !rst;
    assign v_rd_en_o   = w_pop && !rst;
    assign fld_valid_o = (r_state == ST_HOLD) && !rst;
    assign fld_tag_o   = r_tag;
    assign fld_value_o = r_value;
    assign fld_idx_o   = r_idx;
    assign fld_sof_o   = r_sof;
    assign fld_eof_o   = r_eof;
    assign msg_cnt_o   = r_msg_cnt;
    assign err_o       = (w_desync || w_cls_err) && !rst;
    assign err_code_o  = r_err_code;

endmodule

// File: tb/tb_fix_field_sequencer.sv
// Directed bench for fix_field_sequencer with behavioural tag/value FIFOs.
module tb_fix_field_sequencer;

    localparam int TAG_W = 32;
    localparam int VAL_W = 256;
    localparam int IDX_W = 8;
    localparam int MAXF  = 4;
    localparam int DCYC  = 255;

    localparam logic [31:0] T8  = 32'h0000_0038;
    localparam logic [31:0] T9  = 32'h0000_0039;
    localparam logic [31:0] T35 = 32'h0000_3335;
    localparam logic [31:0] T10 = 32'h0000_3130;
    localparam logic [31:0] T49 = 32'h0000_3439;
    localparam logic [31:0] T52 = 32'h0000_3532;

    logic             clk = 1'b0;
    logic             rst;
    logic             t_empty, v_empty, t_rd_en, v_rd_en;
    logic [TAG_W-1:0] t_data;
    logic [VAL_W-1:0] v_data;
    logic             fld_valid, fld_ready;
    logic [TAG_W-1:0] fld_tag;
    logic [VAL_W-1:0] fld_value;
    logic [IDX_W-1:0] fld_idx;
    logic             fld_sof, fld_eof;
    logic [15:0]      msg_cnt;
    logic             err;
    logic [2:0]       err_code;

    always #5 clk = ~clk;

    fix_field_sequencer #(
        .TAG_W(TAG_W), .VAL_W(VAL_W), .IDX_W(IDX_W), .MAX_FIELDS(MAXF), .DESYNC_CYC(DCYC)
    ) dut (
        .clk(clk), .rst(rst),
        .t_empty_i(t_empty), .t_rd_en_o(t_rd_en), .t_data_i(t_data),
        .v_empty_i(v_empty), .v_rd_en_o(v_rd_en), .v_data_i(v_data),
        .fld_valid_o(fld_valid), .fld_ready_i(fld_ready),
        .fld_tag_o(fld_tag), .fld_value_o(fld_value), .fld_idx_o(fld_idx),
        .fld_sof_o(fld_sof), .fld_eof_o(fld_eof),
        .msg_cnt_o(msg_cnt), .err_o(err), .err_code_o(err_code)
    );

    // FIFO models: pushes from the stimulus, pops return data on the following cycle
    logic [TAG_W-1:0] t_mem [0:63];
    logic [VAL_W-1:0] v_mem [0:63];
    int t_wp = 0, t_rp = 0, v_wp = 0, v_rp = 0;

    assign t_empty = (t_wp == t_rp);
    assign v_empty = (v_wp == v_rp);

    always @(posedge clk) begin
        if (t_rd_en) begin
            t_data <= t_mem[t_rp];
            t_rp   <= t_rp + 1;
        end
        if (v_rd_en) begin
            v_data <= v_mem[v_rp];
            v_rp   <= v_rp + 1;
        end
    end

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [VAL_W-1:0] value;
        logic [IDX_W-1:0] idx;
        logic             sof;
        logic             eof;
    } rec_t;

    rec_t       recs[$];
    logic [2:0] codes[$];
    int         pops = 0, err_pulses = 0, pop_skew = 0;
    logic       err_d = 1'b0;

    always @(negedge clk) begin
        if (fld_valid && fld_ready)
            recs.push_back('{tag: fld_tag, value: fld_value, idx: fld_idx, sof: fld_sof, eof: fld_eof});
        if (t_rd_en) pops <= pops + 1;
        if (t_rd_en !== v_rd_en) pop_skew <= pop_skew + 1;
        if (err) err_pulses <= err_pulses + 1;
        if (err_d) codes.push_back(err_code);
        err_d <= err;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [VAL_W-1:0] got, input logic [VAL_W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [VAL_W-1:0] val_of(input logic [TAG_W-1:0] tag);
        return {8{tag ^ 32'hA5A5_0000}};
    endfunction

    task automatic push_tag(input logic [TAG_W-1:0] tag);
        t_mem[t_wp] = tag;
        t_wp++;
    endtask

    task automatic push_val(input logic [VAL_W-1:0] val);
        v_mem[v_wp] = val;
        v_wp++;
    endtask

    task automatic push_pair(input logic [TAG_W-1:0] tag);
        push_tag(tag);
        push_val(val_of(tag));
    endtask

    task automatic chk_rec(input string nm, input int i, input logic [TAG_W-1:0] tag,
                           input int idx, input logic sof, input logic eof);
        chk({nm, "_present"}, recs.size() > i, 1);
        if (recs.size() > i) begin
            chk({nm, "_tag"}, recs[i].tag, tag);
            chk({nm, "_idx"}, recs[i].idx, idx);
            chk({nm, "_sof"}, recs[i].sof, sof);
            chk({nm, "_eof"}, recs[i].eof, eof);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got no end expected end");
        $fatal(1, "timeout");
    end

    initial begin
        int base, e0, c0, p0, k, first, npulse, ppop;
        logic [TAG_W-1:0] hold_tag;

        rst       = 1'b1;
        fld_ready = 1'b0;
        cycles(3);
        chk("rst_valid",   fld_valid, 0);
        chk("rst_rd_en",   t_rd_en,   0);
        chk("rst_err",     err,       0);
        chk("rst_code",    err_code,  0);
        chk("rst_msg_cnt", msg_cnt,   0);
        chk("rst_tag",     fld_tag,   0);
        chk("rst_idx",     fld_idx,   0);
        chk("rst_sof",     fld_sof,   0);
        rst = 1'b0;
        cycles(2);

        // full message streamed with ready held high
        fld_ready = 1'b1;
        base = recs.size();
        e0   = err_pulses;
        push_pair(T8); push_pair(T9); push_pair(T35); push_pair(T10);
        cycles(30);
        chk("t1_nrec", recs.size() - base, 4);
        chk_rec("t1_r0", base + 0, T8,  0, 1, 0);
        chk_rec("t1_r1", base + 1, T9,  1, 0, 0);
        chk_rec("t1_r2", base + 2, T35, 2, 0, 0);
        chk_rec("t1_r3", base + 3, T10, 3, 0, 1);
        if (recs.size() > base + 2) chk("t1_value", recs[base + 2].value, val_of(T35));
        chk("t1_msg_cnt", msg_cnt, 1);
        chk("t1_errs", err_pulses - e0, 0);

        // backpressure: record held, no pops while the next pair waits
        fld_ready = 1'b0;
        base = recs.size();
        push_pair(T8);
        k = 0;
        @(negedge clk);
        while (!t_rd_en && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("t2_pop_seen", t_rd_en, 1);
        repeat (2) @(negedge clk);
        chk("t2_lat_pre", fld_valid, 0);
        @(negedge clk);
        chk("t2_lat", fld_valid, 1);
        push_pair(T10);
        p0       = pops;
        hold_tag = fld_tag;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t2_hold_valid", fld_valid, 1);
            chk("t2_hold_tag", fld_tag, T8);
        end
        chk("t2_hold_stable", fld_tag, hold_tag);
        chk("t2_hold_idx", fld_idx, 0);
        chk("t2_hold_sof", fld_sof, 1);
        chk("t2_hold_val", fld_value, val_of(T8));
        chk("t2_no_pops", pops - p0, 0);
        @(posedge clk);
        #1 fld_ready = 1'b1;
        cycles(20);
        chk("t2_nrec", recs.size() - base, 2);
        chk_rec("t2_r1", base + 1, T10, 1, 0, 1);
        chk("t2_msg_cnt", msg_cnt, 2);

        // orphan field before a message start
        base = recs.size();
        e0   = err_pulses;
        c0   = codes.size();
        push_pair(T35); push_pair(T8); push_pair(T10);
        cycles(40);
        chk("t3_nrec", recs.size() - base, 2);
        chk_rec("t3_r0", base + 0, T8,  0, 1, 0);
        chk_rec("t3_r1", base + 1, T10, 1, 0, 1);
        chk("t3_errs", err_pulses - e0, 1);
        chk("t3_code", err_code, 1);
        chk("t3_msg_cnt", msg_cnt, 3);

        // message restarted without a trailer
        base = recs.size();
        e0   = err_pulses;
        push_pair(T8); push_pair(T9); push_pair(T8); push_pair(T10);
        cycles(40);
        chk("t4_nrec", recs.size() - base, 4);
        chk_rec("t4_r2", base + 2, T8,  0, 1, 0);
        chk_rec("t4_r3", base + 3, T10, 1, 0, 1);
        chk("t4_errs", err_pulses - e0, 1);
        chk("t4_code", err_code, 2);
        chk("t4_msg_cnt", msg_cnt, 4);

        // field count limit reached, then stray trailer
        base = recs.size();
        c0   = codes.size();
        push_pair(T8); push_pair(T9); push_pair(T35); push_pair(T49); push_pair(T52); push_pair(T10);
        cycles(50);
        chk("t5_nrec", recs.size() - base, 4);
        chk_rec("t5_r3", base + 3, T49, 3, 0, 0);
        chk("t5_ncodes", codes.size() - c0, 2);
        if (codes.size() - c0 == 2) begin
            chk("t5_code_ovf", codes[c0], 3);
            chk("t5_code_orphan", codes[c0 + 1], 1);
        end
        chk("t5_msg_cnt", msg_cnt, 4);

        // one FIFO non-empty alone long enough to trip the watchdog
        fld_ready = 1'b0;
        p0     = pops;
        first  = -1;
        npulse = 0;
        ppop   = 0;
        push_tag(T8);
        for (int i = 1; i <= 260; i++) begin
            @(negedge clk);
            if (err) begin
                npulse++;
                if (first < 0) first = i;
            end
            if (t_rd_en || v_rd_en) ppop++;
        end
        chk("t6_first_pulse", first, DCYC);
        chk("t6_npulse", npulse, 1);
        chk("t6_no_pops", ppop, 0);
        chk("t6_code", err_code, 4);
        push_val(val_of(T8));
        k = 0;
        while (!fld_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("t6_hold_valid", fld_valid, 1);
        chk("t6_hold_tag", fld_tag, T8);
        @(posedge clk);
        #1 rst = 1'b1;
        cycles(1);
        chk("t6_rst_valid",   fld_valid, 0);
        chk("t6_rst_rd_en",   t_rd_en,   0);
        chk("t6_rst_err",     err,       0);
        chk("t6_rst_code",    err_code,  0);
        chk("t6_rst_msg_cnt", msg_cnt,   0);
        chk("t6_rst_tag",     fld_tag,   0);
        chk("t6_rst_value",   fld_value, 0);
        chk("t6_rst_sof",     fld_sof,   0);
        rst = 1'b0;

        // after reset, fields before the next "8" are discarded
        fld_ready = 1'b1;
        base = recs.size();
        push_pair(T9); push_pair(T8); push_pair(T10);
        cycles(40);
        chk("t7_nrec", recs.size() - base, 2);
        chk_rec("t7_r0", base + 0, T8, 0, 1, 0);
        chk("t7_code", err_code, 1);
        chk("t7_msg_cnt", msg_cnt, 1);
        chk("pop_pairing", pop_skew, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
